pc_control_unit: RTL and testbench

PC_CONTROL_UNIT -- requirements
Module: pc_control_unit

---
 rtl/pc_control_unit.sv | 152 +++++++++++++++
 tb/tb_pc_control_unit.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/pc_control_unit.sv
// pc_control_unit: PC/nPC register pair with a +4 incrementer, plus a
// purely combinational decoder that turns the current instruction into a
// 20-bit control word for the rest of the datapath.
module pc_control_unit (
  input  logic        clk,
  input  logic        clr,
  input  logic        LE,
  input  logic [31:0] instr,
  output logic [31:0] PC,
  output logic [31:0] nPC,
  output logic [31:0] nPC4,
  output logic [19:0] instr_signals
);

  logic [31:0] pc_reg;
  logic [31:0] npc_reg;

  logic [1:0] op;
  logic [2:0] op2;
  logic [5:0] op3;

  logic       jmpl_sig;
  logic       call_sig;
  logic       load_sig;
  logic       rf_enable;
  logic       mem_sign_extend;
  logic       mem_rw;
  logic       mem_enable;
  logic [1:0] mem_size;
  logic       cc_enable;
  logic [3:0] alu_op;
  logic       branch_sig;
  logic       annul_sig;

  assign op  = instr[31:30];
  assign op2 = instr[24:22];
  assign op3 = instr[24:19];

  assign PC   = pc_reg;
  assign nPC  = npc_reg;
  // The adder is 32 bits wide on purpose so the carry-out falls away and
  // the address space wraps from 0xFFFFFFFC back to zero.
  assign nPC4 = npc_reg + 32'd4;

  // Clear restarts the pair at 0/4 and beats load enable; otherwise the pair
  // advances one instruction together or holds.
  always_ff @(posedge clk) begin
    if (clr) begin
      pc_reg  <= 32'h0000_0000;
      npc_reg <= 32'h0000_0004;
    end else if (LE) begin
      pc_reg  <= npc_reg;
      npc_reg <= nPC4;
    end
  end

  // Instruction-class decode: every control bit starts at zero and only the
  // bits belonging to the recognised class are raised.
  always_comb begin
    jmpl_sig        = 1'b0;
    call_sig        = 1'b0;
    load_sig        = 1'b0;
    rf_enable       = 1'b0;
    mem_sign_extend = 1'b0;
    mem_rw          = 1'b0;
    mem_enable      = 1'b0;
    mem_size        = 2'b00;
    cc_enable       = 1'b0;
    alu_op          = 4'b0000;
    branch_sig      = 1'b0;
    annul_sig       = 1'b0;

    case (op)
      2'b01: begin
        call_sig  = 1'b1;
        rf_enable = 1'b1;
      end
      2'b00: begin
        if (op2 == 3'b010) begin
          branch_sig = 1'b1;
          annul_sig  = instr[29];
        end else if (op2 == 3'b100) begin
          rf_enable = 1'b1;
          alu_op    = 4'b1110;
        end
      end
      2'b10: begin
        if (op3 == 6'b111000) begin
          jmpl_sig  = 1'b1;
          rf_enable = 1'b1;
        end else if (!op3[5]) begin
          rf_enable = 1'b1;
          cc_enable = op3[4];
          alu_op    = op3[3:0];
        end else begin
          case (op3)
            6'b100101: begin
              rf_enable = 1'b1;
              cc_enable = op3[4];
              alu_op    = 4'b1010;
            end
            6'b100110: begin
              rf_enable = 1'b1;
              cc_enable = op3[4];
              alu_op    = 4'b1011;
            end
            6'b100111: begin
              rf_enable = 1'b1;
              cc_enable = op3[4];
              alu_op    = 4'b1101;
            end
            default: begin
              rf_enable = 1'b0;
              alu_op    = 4'b0000;
            end
          endcase
        end
      end
      default: begin
        mem_enable      = 1'b1;
        mem_rw          = op3[2];
        load_sig        = ~op3[2];
        rf_enable       = ~op3[2];
        mem_sign_extend = op3[3] & ~op3[2];
        case (op3[1:0])
          2'b00:   mem_size = 2'b10;
          2'b01:   mem_size = 2'b00;
          2'b10:   mem_size = 2'b01;
          default: mem_size = 2'b11;
        endcase
      end
    endcase
  end

  assign instr_signals = {annul_sig & branch_sig,
                          branch_sig,
                          alu_op,
                          instr[13],
                          instr[24],
                          instr[30],
                          instr[31],
                          cc_enable,
                          mem_size,
                          mem_enable,
                          mem_rw,
                          mem_sign_extend,
                          rf_enable,
                          load_sig,
                          call_sig,
                          jmpl_sig};

endmodule

// File: tb/tb_pc_control_unit.sv
// tb_pc_control_unit: directed checks of the PC/nPC pair and the decoder.
module tb_pc_control_unit;

  logic        clk;
  logic        clr;
  logic        LE;
  logic [31:0] instr;
  logic [31:0] PC;
  logic [31:0] nPC;
  logic [31:0] nPC4;
  logic [19:0] instr_signals;

  int tests_run;
  int tests_failed;

  pc_control_unit dut (
    .clk          (clk),
    .clr          (clr),
    .LE           (LE),
    .instr        (instr),
    .PC           (PC),
    .nPC          (nPC),
    .nPC4         (nPC4),
    .instr_signals(instr_signals)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drives inputs on the falling edge, then lets one rising edge pass and
  // settles 1 unit past it before returning.
  task automatic applyStimulus(input logic c, input logic le, input logic [31:0] ins);
    @(negedge clk);
    clr   = c;
    LE    = le;
    instr = ins;
    @(posedge clk);
    #1;
  endtask

  // Sets only the instruction and lets the combinational decode settle.
  task automatic setInstr(input logic [31:0] ins);
    instr = ins;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Directed sequence: counter behaviour first, then decode vectors.
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    clr   = 1'b0;
    LE    = 1'b0;
    instr = 32'h0000_0000;

    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("reset_pc",   PC,   32'h0);
    checkOutput("reset_npc",  nPC,  32'h4);
    checkOutput("reset_npc4", nPC4, 32'h8);

    applyStimulus(1'b0, 1'b1, 32'h0);
    checkOutput("adv1_pc",  PC,  32'd4);
    checkOutput("adv1_npc", nPC, 32'd8);
    applyStimulus(1'b0, 1'b1, 32'h0);
    checkOutput("adv2_pc",  PC,  32'd8);
    checkOutput("adv2_npc", nPC, 32'd12);
    applyStimulus(1'b0, 1'b1, 32'h0);
    checkOutput("adv3_pc",   PC,   32'd12);
    checkOutput("adv3_npc",  nPC,  32'd16);
    checkOutput("adv3_npc4", nPC4, 32'd20);

    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("hold_pc",  PC,  32'd12);
    checkOutput("hold_npc", nPC, 32'd16);

    // Clear to 0/4, advance to PC=8, then clear while LE is still high.
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h0);
    checkOutput("pre_clr_pc", PC, 32'd8);
    applyStimulus(1'b1, 1'b1, 32'h0);
    checkOutput("midclr_pc",  PC,  32'd0);
    checkOutput("midclr_npc", nPC, 32'd4);
    applyStimulus(1'b0, 1'b1, 32'h0);
    checkOutput("resume_pc",  PC,  32'd4);
    checkOutput("resume_npc", nPC, 32'd8);

    // Place nPC at the top of the address space and take one step.
    @(negedge clk);
    LE = 1'b0;
    force dut.npc_reg = 32'hFFFF_FFFC;
    #1;
    checkOutput("wrap_npc4", nPC4, 32'h0);
    release dut.npc_reg;
    #1;
    applyStimulus(1'b0, 1'b1, 32'h0);
    checkOutput("wrap_pc",  PC,  32'hFFFF_FFFC);
    checkOutput("wrap_npc", nPC, 32'h0);

    // Clear with LE low still restores 0/4; decode stays live during clear.
    applyStimulus(1'b1, 1'b0, 32'h8600_4002);
    checkOutput("clr_le0_pc",  PC,  32'h0);
    checkOutput("clr_le0_npc", nPC, 32'h4);
    checkOutput("dec_add_during_clr", {12'h0, instr_signals}, 32'h0_0408);
    @(negedge clk);
    clr = 1'b0;

    setInstr(32'h86A0_4002);
    checkOutput("dec_subcc", {12'h0, instr_signals}, 32'h1_0608);
    setInstr(32'hC248_0000);
    checkOutput("dec_ldsb", {12'h0, instr_signals}, 32'h0_0C5C);
    setInstr(32'hC220_0000);
    checkOutput("dec_st", {12'h0, instr_signals}, 32'h0_0D60);
    setInstr(32'h4000_0010);
    checkOutput("dec_call", {12'h0, instr_signals}, 32'h0_080A);
    setInstr(32'h1080_0004);
    checkOutput("dec_ba", {12'h0, instr_signals}, 32'h4_0000);
    setInstr(32'h3080_0004);
    checkOutput("dec_ba_annul", {12'h0, instr_signals}, 32'hC_0000);
    setInstr(32'h0300_0000);
    checkOutput("dec_sethi", {12'h0, instr_signals}, 32'h3_9008);
    setInstr({2'b10, 5'd15, 6'b111000, 5'd1, 1'b1, 13'd8});
    checkOutput("dec_jmpl", {12'h0, instr_signals}, 32'h0_3409);
    setInstr({2'b10, 5'd3, 6'b100101, 5'd1, 1'b0, 13'd2});
    checkOutput("dec_sll", {12'h0, instr_signals}, 32'h2_9408);
    setInstr(32'h0000_2000);
    checkOutput("dec_op00_other", {12'h0, instr_signals}, 32'h0_2000);
    setInstr(32'h0000_0000);
    checkOutput("dec_zero", {12'h0, instr_signals}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
